// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, HI/LO opcodes and default width for the mul/div sequencer
package muldiv_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [5:0] OP_MULT = 6'b011010;
  localparam logic [5:0] OP_DIV  = 6'b101010;
  localparam logic [5:0] OP_MFHI = 6'b011000;
  localparam logic [5:0] OP_MFLO = 6'b010000;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negation; neg selects y=-a, otherwise y=a
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: WIDTH-iteration signed shift-add MULT / restoring DIV writing HI/LO; ports: start_mult/start_div/mf_req/flush/rs_val/rt_val in, busy/stall/done/div_zero/hi/lo out
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             mf_req,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_mag, b_mag, rs_mag, rt_mag, rem_fix, quo_fix, rsub;
  logic [2*WIDTH-1:0] p, p_nxt, prod_fix;
  logic [WIDTH:0] sum, sh;
  logic sa, sb, is_div, start, last, ge;
  assign start = start_mult | start_div;
  assign last = cnt == CNT_W'(WIDTH-1);
  muldiv_negate #(.W(WIDTH)) u_rs (.neg(rs_val[WIDTH-1]), .a(rs_val), .y(rs_mag));
  muldiv_negate #(.W(WIDTH)) u_rt (.neg(rt_val[WIDTH-1]), .a(rt_val), .y(rt_mag));
  muldiv_negate #(.W(2*WIDTH)) u_prod (.neg(sa ^ sb), .a(p), .y(prod_fix));
  muldiv_negate #(.W(WIDTH)) u_quo (.neg(sa ^ sb), .a(p[WIDTH-1:0]), .y(quo_fix));
  // a zero divisor returns the original dividend, rebuilt from its magnitude and sign
  muldiv_negate #(.W(WIDTH)) u_rem (
    .neg(sa),
    .a(b_mag == '0 ? a_mag : p[2*WIDTH-1:WIDTH]),
    .y(rem_fix)
  );
  // p holds {acc, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? a_mag : '0};
    sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    ge = sh >= {1'b0, b_mag};
    rsub = sh[WIDTH-1:0] - b_mag;
    p_nxt = is_div ? {ge ? rsub : sh[WIDTH-1:0], p[WIDTH-2:0], ge} : {sum, p[WIDTH-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = flush ? IDLE
              : state == IDLE ? (start ? RUN : IDLE)
              : state == RUN ? (last ? FIX : RUN)
              : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    stall = busy & (mf_req | start);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      p <= '0;
      a_mag <= '0;
      b_mag <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      is_div <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      if (!flush) begin
        if (state == IDLE && start) begin
          a_mag <= rs_mag;
          b_mag <= rt_mag;
          sa <= rs_val[WIDTH-1];
          sb <= rt_val[WIDTH-1];
          is_div <= !start_mult;
          cnt <= '0;
          p <= {{WIDTH{1'b0}}, start_mult ? rt_mag : rs_mag};
        end else if (state == RUN) begin
          p <= p_nxt;
          cnt <= cnt + 1'b1;
        end else if (state == FIX) begin
          hi <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo <= is_div ? (b_mag == '0 ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
          done <= 1'b1;
          div_zero <= is_div & (b_mag == '0);
        end
      end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: vector table, random ops against an arithmetic model, and hazard/flush/reset sequences
module tb_muldiv_sequencer;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start_mult = 1'b0, start_div = 1'b0, mf_req = 1'b0, flush = 1'b0;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic busy, stall, done, div_zero;
  logic [W-1:0] hi, lo;
  int errs = 0, checks = 0;
  typedef struct {
    bit m;
    logic [31:0] a, b, h, l;
    bit dz;
  } vec_t;
  vec_t tv[10];
  always #5 clk = ~clk;
  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .start_div(start_div),
    .mf_req(mf_req), .flush(flush), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .stall(stall), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p;
    dz = 1'b0;
    if (is_mult) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a;
      l = '1;
      dz = 1'b1;
    end else begin
      p = sa / sb;
      l = p[31:0];
      p = sa % sb;
      h = p[31:0];
    end
  endfunction
  // lat counts falling edges after the start edge; done is expected at lat 34
  task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                     input int mf_at, input int dv_at, input int fl_at,
                     output int lat, output int bc, output int sc, output bit dn);
    @(negedge clk);
    start_mult = m;
    start_div = d;
    rs_val = a;
    rt_val = b;
    lat = 0;
    bc = 0;
    sc = 0;
    do begin
      @(negedge clk);
      lat++;
      start_mult = 1'b0;
      start_div = (lat == dv_at);
      if (lat == mf_at) mf_req = 1'b1;
      flush = (lat == fl_at);
      #1;
      bc += int'(busy);
      sc += int'(stall);
    end while (!done && lat < 60 && !(fl_at > 0 && lat >= fl_at + 4));
    dn = done;
    flush = 1'b0;
    start_div = 1'b0;
  endtask
  initial begin
    int lat, bc, sc;
    bit dn;
    logic [31:0] eh, el;
    bit edz, m;
    logic [31:0] a, b;
    tv[0] = '{1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[1] = '{1'b0, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0};
    tv[2] = '{1'b0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
    tv[3] = '{1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1};
    tv[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
    tv[5] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0};
    tv[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0};
    tv[7] = '{1'b0, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
    tv[8] = '{1'b1, 32'd0, 32'd12345, 32'd0, 32'd0, 1'b0};
    tv[9] = '{1'b0, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0};
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", div_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(tv[i].m, !tv[i].m, tv[i].a, tv[i].b, 0, 0, 0, lat, bc, sc, dn);
      chk($sformatf("vec%0d_latency", i), lat, 34);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 33);
      chk($sformatf("vec%0d_hi", i), hi, tv[i].h);
      chk($sformatf("vec%0d_lo", i), lo, tv[i].l);
      chk($sformatf("vec%0d_div_zero", i), div_zero, tv[i].dz);
      @(negedge clk);
      chk($sformatf("vec%0d_done_drop", i), done, 0);
      chk($sformatf("vec%0d_dz_drop", i), div_zero, 0);
    end
    for (int i = 0; i < 24; i++) begin
      m = 1'(($urandom & 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) a = {1'b1, 31'($urandom_range(0, 1))};
      model(m, a, b, eh, el, edz);
      run(m, !m, a, b, 0, 0, 0, lat, bc, sc, dn);
      chk($sformatf("rnd%0d_%s_%0h_%0h_latency", i, m ? "mult" : "div", a, b), lat, 34);
      chk($sformatf("rnd%0d_%s_%0h_%0h_hi", i, m ? "mult" : "div", a, b), hi, eh);
      chk($sformatf("rnd%0d_%s_%0h_%0h_lo", i, m ? "mult" : "div", a, b), lo, el);
      chk($sformatf("rnd%0d_%s_%0h_%0h_dz", i, m ? "mult" : "div", a, b), div_zero, edz);
    end
    run(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 5, 10, 0, lat, bc, sc, dn);
    chk("hazard_latency", lat, 34);
    chk("hazard_stall_cycles", sc, 29);
    chk("hazard_stall_at_done", stall, 0);
    chk("hazard_hi", hi, 32'hFFFFFFFF);
    chk("hazard_lo", lo, 32'hFFFFFFEB);
    mf_req = 1'b0;
    #1;
    chk("hazard_stall_release", stall, 0);
    run(1'b1, 1'b1, 32'd6, 32'd7, 0, 0, 0, lat, bc, sc, dn);
    chk("both_start_lo", lo, 42);
    chk("both_start_hi", hi, 0);
    chk("both_start_dz", div_zero, 0);
    run(1'b1, 1'b0, 32'd3, 32'd4, 0, 0, 0, lat, bc, sc, dn);
    chk("preload_lo", lo, 12);
    run(1'b0, 1'b1, 32'd100, 32'd7, 0, 0, 10, lat, bc, sc, dn);
    chk("flush_busy_cycles", bc, 10);
    chk("flush_no_done", dn, 0);
    chk("flush_hi", hi, 0);
    chk("flush_lo", lo, 12);
    @(negedge clk);
    start_div = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_beats_start", busy, 0);
    @(negedge clk);
    start_mult = 1'b1;
    rs_val = 32'd9;
    rt_val = 32'd9;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_hi", hi, 0);
    chk("async_lo", lo, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 1'b0, 32'd2, 32'd2, 0, 0, 0, lat, bc, sc, dn);
    chk("post_reset_latency", lat, 34);
    chk("post_reset_lo", lo, 4);
    chk("post_reset_hi", hi, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the HI/LO multiply/divide resource behind the MULT, DIV, MFHI and MFLO opcodes. It takes one start pulse and two operands from decode. It runs a WIDTH-iteration shift-add multiply or restoring divide, applies sign correction, then writes HI/LO. While an operation is in flight it stalls MFHI/MFLO and any new MULT/DIV, so the single-cycle pipeline never reads stale HI/LO.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start_mult  in  1  decoded MULT; one-cycle request.
start_div  in  1  decoded DIV; one-cycle request.
mf_req  in  1  decoded MFHI or MFLO in the current instruction.
flush  in  1  abort the in-flight operation.
rs_val  in  WIDTH  operand A: multiplicand or dividend, signed.
rt_val  in  WIDTH  operand B: multiplier or divisor, signed.
busy  out  1  operation in flight.
stall  out  1  hold the pipeline.
done  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
div_zero  out  1  one-cycle pulse with done; the divisor was 0.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_zero=0. Any operation in progress is discarded.
- States and transitions:
  - IDLE -> RUN when start_mult|start_div is sampled. Capture |rs_val|, |rt_val|, sign flags and op type; counter=0.
  - RUN: one iteration per edge, counter increments. After iteration WIDTH-1 the state goes to FIX.
  - FIX: apply sign correction, write hi/lo, go to IDLE. done=1 in the following cycle.
- Latency: start sampled at edge E0; iterations at E1..E32; hi/lo written at E33; done=1 during the cycle after E33. Total is WIDTH+1 edges from start to result.
- busy=1 whenever state is RUN or FIX (registered).
- stall = busy & (mf_req | start_mult | start_div); it is combinational.
- Requests while busy:
  - start_mult/start_div while busy are ignored by the sequencer. The stall guarantees decode re-presents them after done.
  - start_mult and start_div asserted together: MULT wins.
- MULT:
  - 2*WIDTH-bit magnitude product using shift-add.
  - Negate the full 2*WIDTH product if sign(A)!=sign(B).
  - hi=product[2W-1:W], lo=product[W-1:0].
- DIV:
  - Restoring division on magnitudes.
  - Quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
  - -2^31 / -1 gives lo=0x80000000, hi=0. No exception is raised.
- Divide by zero (rt_val==0 captured at start): the sequence still runs the full latency. At FIX, hi=rs_val (original), lo=all ones, div_zero=1 together with done.
- flush:
  - In RUN or FIX: next edge goes to IDLE, busy=0, hi/lo unchanged, no done.
  - flush has priority over a start in the same cycle; that start is dropped.
- hi/lo change only at FIX or reset; they are stable at all other times.

Decomposition:
- Package muldiv_pkg holds:
  - state enum IDLE/RUN/FIX;
  - opcode constants OP_MULT=6'b011010, OP_DIV=6'b101010, OP_MFHI=6'b011000, OP_MFLO=6'b010000;
  - default WIDTH.
- One sub-module, muldiv_negate: combinational conditional two's-complement negation (width-parameterised). It is instantiated for operand magnitude, product fix, quotient fix and remainder fix.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) -> done 34 cycles after start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy=1 for 33 cycles.
- DIV rs=100, rt=0xFFFFFFF9 (-7) -> lo=0xFFFFFFF2 (-14), hi=2. Repeat with rs=-100, rt=7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE.
- DIV rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF, div_zero=1 and done=1 in the same cycle, both 0 the next cycle.
- Hazards during a MULT:
  - mf_req=1 at cycle 5 -> stall=1 every cycle until done, 0 when mf_req drops.
  - start_div pulsed at cycle 10 -> ignored; result equals the MULT.
  - Simultaneous start_mult+start_div from IDLE -> MULT result.
- Preload hi/lo via MULT 3*4 (lo=12), then start DIV and assert flush at cycle 10 -> busy=0 next edge, no done, hi=0, lo=12 retained.
- Assert rst_n=0 asynchronously mid-RUN (between edges) -> busy, hi, lo, done go to 0 immediately. After release a new MULT 2*2 gives lo=4.
